// File: rtl/alu_6_bit_issue_stage_pkg.sv
// rtl/alu_6_bit_issue_stage_pkg.sv - shared widths, state encoding and ALUop constants
package alu_6_bit_issue_stage_pkg;

    localparam int PKG_W     = 6;
    localparam int PKG_NREGS = 8;
    localparam int PKG_AW    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

endpackage

// File: rtl/alu_6_bit_issue_stage_if.sv
// rtl/alu_6_bit_issue_stage_if.sv - instruction issue handshake bundle
interface alu_6_bit_issue_stage_if;
    import alu_6_bit_issue_stage_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [3:0]          instr_op;
    logic [PKG_AW-1:0]   instr_rd;
    logic [PKG_AW-1:0]   instr_rs1;
    logic [PKG_AW-1:0]   instr_rs2;
    logic                instr_use_carry;

    modport master (
        output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_carry,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_carry,
        output instr_ready
    );
endinterface

// File: rtl/alu_6_bit_issue_stage_regfile.sv
// rtl/alu_6_bit_issue_stage_regfile.sv - 8x6 register file with latched operand reads
module alu_regfile_8x6
    import alu_6_bit_issue_stage_pkg::*;
#(
    parameter int NREGS = PKG_NREGS,
    parameter int W     = PKG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_rd_en,
    input  logic [PKG_AW-1:0] i_rs1,
    input  logic [PKG_AW-1:0] i_rs2,
    output logic [W-1:0]      o_rdata1,
    output logic [W-1:0]      o_rdata2,
    input  logic [PKG_AW-1:0] i_dbg_addr,
    output logic [W-1:0]      o_dbg_data,
    input  logic              i_host_we,
    input  logic [PKG_AW-1:0] i_host_addr,
    input  logic [W-1:0]      i_host_data,
    input  logic              i_alu_we,
    input  logic [PKG_AW-1:0] i_alu_addr,
    input  logic [W-1:0]      i_alu_data
);

    logic [W-1:0] r_mem [NREGS];
    logic [W-1:0] r_rdata1;
    logic [W-1:0] r_rdata2;

    // r0 is hardwired to zero on every read path, so its storage is never written
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
            r_rdata1 <= '0;
            r_rdata2 <= '0;
        end else begin
            if (i_rd_en) begin
                r_rdata1 <= (i_rs1 == '0) ? '0 : r_mem[i_rs1];
                r_rdata2 <= (i_rs2 == '0) ? '0 : r_mem[i_rs2];
            end
            if (i_alu_we && i_alu_addr != '0)
                r_mem[i_alu_addr] <= i_alu_data;
            else if (i_host_we && i_host_addr != '0)
                r_mem[i_host_addr] <= i_host_data;
        end
    end

    assign o_rdata1   = r_rdata1;
    assign o_rdata2   = r_rdata2;
    assign o_dbg_data = (i_dbg_addr == '0) ? '0 : r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_6_bit_issue_stage.sv
// rtl/alu_6_bit_issue_stage.sv - issue/writeback stage around the 6-bit ALU; CARRY_FLAG_EN adds add-with-carry
module alu_6_bit_issue_stage
    import alu_6_bit_issue_stage_pkg::*;
#(
    parameter int NREGS = PKG_NREGS,
    parameter int W     = PKG_W
) (
    input  logic                     clk,
    input  logic                     reset,
    alu_6_bit_issue_stage_if.slave   instr,
    input  logic                     wr_en,
    input  logic [PKG_AW-1:0]        wr_addr,
    input  logic [W-1:0]             wr_data,
    output logic [W-1:0]             a,
    output logic [W-1:0]             b,
    output logic [3:0]               ALUop,
    output logic                     cin,
    input  logic [W-1:0]             alu_result,
    input  logic                     alu_cout,
    output logic                     done,
    output logic [W-1:0]             result_out,
    input  logic [PKG_AW-1:0]        dbg_addr,
    output logic [W-1:0]             dbg_data
);

    state_t            r_state;
    logic [3:0]        r_alu_op;
    logic              r_cin;
    logic [PKG_AW-1:0] r_rd;
    logic              r_done;
    logic [W-1:0]      r_result;

    logic w_accept;
    logic w_host_we;
    logic w_alu_we;
    logic w_cin;

    assign instr.instr_ready = (r_state == ST_IDLE);
    assign w_accept  = (r_state == ST_IDLE) && instr.instr_valid;
    assign w_host_we = (r_state == ST_IDLE) && wr_en;
    assign w_alu_we  = (r_state == ST_EXEC);

`ifdef CARRY_FLAG_EN
    logic r_carry;
    assign w_cin = instr.instr_op[2] | (instr.instr_use_carry & r_carry);
`else
    logic w_unused;
    assign w_unused = &{1'b0, instr.instr_use_carry, alu_cout};
    assign w_cin = instr.instr_op[2];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_alu_op <= '0;
            r_cin    <= 1'b0;
            r_rd     <= '0;
            r_done   <= 1'b0;
            r_result <= '0;
`ifdef CARRY_FLAG_EN
            r_carry  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (instr.instr_valid) begin
                        r_alu_op <= instr.instr_op;
                        r_rd     <= instr.instr_rd;
                        r_cin    <= w_cin;
                        r_state  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= alu_result;
                    r_done   <= 1'b1;
`ifdef CARRY_FLAG_EN
                    r_carry  <= alu_cout;
`endif
                    r_state  <= ST_WB;
                end
                ST_WB:   r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Operand registers live in the regfile read ports; they drive a/b directly
    alu_regfile_8x6 #(.NREGS(NREGS), .W(W)) u_rf (
        .clk         (clk),
        .reset       (reset),
        .i_rd_en     (w_accept),
        .i_rs1       (instr.instr_rs1),
        .i_rs2       (instr.instr_rs2),
        .o_rdata1    (a),
        .o_rdata2    (b),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data),
        .i_host_we   (w_host_we),
        .i_host_addr (wr_addr),
        .i_host_data (wr_data),
        .i_alu_we    (w_alu_we),
        .i_alu_addr  (r_rd),
        .i_alu_data  (alu_result)
    );

    assign ALUop      = r_alu_op;
    assign cin        = r_cin;
    assign done       = r_done;
    assign result_out = r_result;

endmodule

// File: tb/tb_alu_6_bit_issue_stage.sv
// tb/tb_alu_6_bit_issue_stage.sv - directed bench for the issue/writeback stage
module tb_alu_6_bit_issue_stage;
    import alu_6_bit_issue_stage_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [2:0] dbg_addr = '0;
    logic [5:0] alu_result;
    logic       alu_cout;
    wire  [5:0] a, b, result_out, dbg_data;
    wire  [3:0] ALUop;
    wire        cin, done;

    int errors = 0;
    int checks = 0;

    alu_6_bit_issue_stage_if instr_if ();

    alu_6_bit_issue_stage dut (
        .clk(clk), .reset(reset), .instr(instr_if.slave),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .a(a), .b(b), .ALUop(ALUop), .cin(cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .done(done), .result_out(result_out),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Behavioural 6-bit ripple ALU (ainvert=op[3], binvert=op[2], select=op[1:0])
    logic [5:0] aa, bb;
    logic [6:0] sum;
    always_comb begin
        aa = ALUop[3] ? ~a : a;
        bb = ALUop[2] ? ~b : b;
        sum = {1'b0, aa} + {1'b0, bb} + {6'd0, cin};
        alu_cout = sum[6];
        case (ALUop[1:0])
            2'b00:   alu_result = aa & bb;
            2'b01:   alu_result = aa | bb;
            2'b10:   alu_result = sum[5:0];
            default: alu_result = 6'd0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [2:0] ad, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = ad; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic set_instr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic uc);
        instr_if.instr_op = op; instr_if.instr_rd = rd; instr_if.instr_rs1 = rs1;
        instr_if.instr_rs2 = rs2; instr_if.instr_use_carry = uc;
    endtask

    task automatic accept(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                          input logic [2:0] rs2, input logic uc);
        set_instr(op, rd, rs1, rs2, uc);
        instr_if.instr_valid = 1'b1;
        tick();
        instr_if.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        reset = 1'b0;
        checks++; if (instr_if.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", instr_if.instr_ready); end
        checks++; if ({a, b} !== 12'd0) begin errors++; $display("FAIL rst_ab got=%0d/%0d exp=0/0", a, b); end
        checks++; if ({ALUop, cin, done} !== 6'd0) begin errors++; $display("FAIL rst_ctrl got=%b%b%b exp=000000", ALUop, cin, done); end
        checks++; if (result_out !== 6'd0) begin errors++; $display("FAIL rst_result got=%0d exp=0", result_out); end
    endtask

    task automatic test_add();
        host_write(3'd1, 6'd13);
        host_write(3'd2, 6'd5);
        accept(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        checks++; if ({a, b} !== {6'd13, 6'd5}) begin errors++; $display("FAIL add_ops got=%0d/%0d exp=13/5", a, b); end
        checks++; if ({ALUop, cin} !== {OP_ADD, 1'b0}) begin errors++; $display("FAIL add_opcin got=%b/%b exp=0010/0", ALUop, cin); end
        checks++; if ({instr_if.instr_ready, done} !== 2'b00) begin errors++; $display("FAIL add_exec_flags got=%b%b exp=00", instr_if.instr_ready, done); end
        tick();
        dbg_addr = 3'd3; #1;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got=%b exp=1", done); end
        checks++; if (result_out !== 6'd18) begin errors++; $display("FAIL add_result got=%0d exp=18", result_out); end
        checks++; if (dbg_data !== 6'd18) begin errors++; $display("FAIL add_r3 got=%0d exp=18", dbg_data); end
        tick();
        checks++; if ({instr_if.instr_ready, done} !== 2'b10) begin errors++; $display("FAIL add_idle got=%b%b exp=10", instr_if.instr_ready, done); end
    endtask

    task automatic test_sub();
        host_write(3'd1, 6'd5);
        host_write(3'd2, 6'd13);
        accept(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0);
        checks++; if ({ALUop, cin} !== {OP_SUB, 1'b1}) begin errors++; $display("FAIL sub_opcin got=%b/%b exp=0110/1", ALUop, cin); end
        tick();
        dbg_addr = 3'd4; #1;
        checks++; if (result_out !== 6'd56) begin errors++; $display("FAIL sub_result got=%0d exp=56", result_out); end
        checks++; if (dbg_data !== 6'd56) begin errors++; $display("FAIL sub_r4 got=%0d exp=56", dbg_data); end
        tick();
    endtask

    task automatic test_carry();
        logic [5:0] exp_c;
`ifdef CARRY_FLAG_EN
        exp_c = 6'd1;
`else
        exp_c = 6'd0;
`endif
        host_write(3'd1, 6'd63);
        host_write(3'd2, 6'd1);
        accept(OP_ADD, 3'd5, 3'd1, 3'd2, 1'b0);
        tick();
        dbg_addr = 3'd5; #1;
        checks++; if ({result_out, dbg_data} !== 12'd0) begin errors++; $display("FAIL carry_wrap got=%0d/%0d exp=0/0", result_out, dbg_data); end
        tick();
        accept(OP_ADD, 3'd7, 3'd0, 3'd0, 1'b1);
        checks++; if (cin !== exp_c[0]) begin errors++; $display("FAIL carry_cin got=%b exp=%b", cin, exp_c[0]); end
        tick();
        checks++; if (result_out !== exp_c) begin errors++; $display("FAIL carry_result got=%0d exp=%0d", result_out, exp_c); end
        tick();
    endtask

    task automatic test_back_to_back();
        set_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0);
        instr_if.instr_valid = 1'b1;
        tick();
        set_instr(OP_OR, 3'd4, 3'd1, 3'd2, 1'b0);
        checks++; if ({instr_if.instr_ready, ALUop} !== {1'b0, OP_ADD}) begin errors++; $display("FAIL b2b_exec got=%b/%b exp=0/0010", instr_if.instr_ready, ALUop); end
        tick();
        checks++; if ({instr_if.instr_ready, done, result_out} !== {2'b01, 6'd0}) begin errors++; $display("FAIL b2b_wb got=%b%b/%0d exp=01/0", instr_if.instr_ready, done, result_out); end
        tick();
        checks++; if (instr_if.instr_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_ready got=%b exp=1", instr_if.instr_ready); end
        tick();
        instr_if.instr_valid = 1'b0;
        checks++; if ({ALUop, a, b} !== {OP_OR, 6'd63, 6'd1}) begin errors++; $display("FAIL b2b_second got=%b/%0d/%0d exp=0001/63/1", ALUop, a, b); end
        tick();
        checks++; if (result_out !== 6'd63) begin errors++; $display("FAIL b2b_result got=%0d exp=63", result_out); end
        tick();
    endtask

    task automatic test_host_collide();
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 6'd7;
        accept(OP_ADD, 3'd2, 3'd1, 3'd0, 1'b0);
        wr_en = 1'b0;
        dbg_addr = 3'd1; #1;
        checks++; if (a !== 6'd63) begin errors++; $display("FAIL coll_old_a got=%0d exp=63", a); end
        checks++; if (dbg_data !== 6'd7) begin errors++; $display("FAIL coll_r1 got=%0d exp=7", dbg_data); end
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 6'd9;
        tick();
        wr_en = 1'b0;
        dbg_addr = 3'd2; #1;
        checks++; if (dbg_data !== 6'd63) begin errors++; $display("FAIL coll_r2 got=%0d exp=63", dbg_data); end
        tick();
        dbg_addr = 3'd6; #1;
        checks++; if (dbg_data !== 6'd0) begin errors++; $display("FAIL exec_write_ignored got=%0d exp=0", dbg_data); end
    endtask

    task automatic test_r0();
        host_write(3'd0, 6'd33);
        dbg_addr = 3'd0; #1;
        checks++; if (dbg_data !== 6'd0) begin errors++; $display("FAIL r0_host got=%0d exp=0", dbg_data); end
        accept(OP_ADD, 3'd0, 3'd1, 3'd1, 1'b0);
        tick();
        checks++; if ({done, result_out} !== {1'b1, 6'd14}) begin errors++; $display("FAIL r0_wb got=%b/%0d exp=1/14", done, result_out); end
        checks++; if (dbg_data !== 6'd0) begin errors++; $display("FAIL r0_alu got=%0d exp=0", dbg_data); end
        tick();
    endtask

    task automatic test_reset_exec();
        host_write(3'd1, 6'd3);
        accept(OP_ADD, 3'd6, 3'd1, 3'd1, 1'b0);
        checks++; if (a !== 6'd3) begin errors++; $display("FAIL rexec_a got=%0d exp=3", a); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dbg_addr = 3'd6; #1;
        checks++; if ({instr_if.instr_ready, done} !== 2'b10) begin errors++; $display("FAIL rexec_flags got=%b%b exp=10", instr_if.instr_ready, done); end
        checks++; if ({a, b, ALUop, cin, result_out} !== 23'd0) begin errors++; $display("FAIL rexec_outs got=%0d/%0d/%b/%b/%0d exp=0", a, b, ALUop, cin, result_out); end
        checks++; if (dbg_data !== 6'd0) begin errors++; $display("FAIL rexec_r6 got=%0d exp=0", dbg_data); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rexec_late_done got=%b exp=0", done); end
    endtask

    initial begin
        instr_if.instr_valid = 1'b0;
        set_instr(4'd0, 3'd0, 3'd0, 3'd0, 1'b0);
        test_reset();
        test_add();
        test_sub();
        test_carry();
        test_back_to_back();
        test_host_collide();
        test_r0();
        test_reset_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
